// File: rtl/dmem_responder_pkg.sv
// Shared access-size encodings, FSM states and lane helpers for the data-memory path.
// The byte-enable helper is also used by the MEM stage when it builds a request.
package dmem_responder_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_HOLD
  } state_t;

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_B:  byte_en = 4'b0001 << lo;
      SIZE_H:  byte_en = 4'b0011 << lo;
      SIZE_W:  byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  endfunction

  // Right-justified store data copied into every lane it could land in.
  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SIZE_B:  lane_data = {4{wdata[7:0]}};
      SIZE_H:  lane_data = {2{wdata[15:0]}};
      default: lane_data = wdata;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bank_byte.sv
// One 8-bit byte lane of data storage: synchronous write, asynchronous read.
// A read on the write edge returns the pre-write contents.
module dmem_bank_byte #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [7:0]               wdata,
  output logic [7:0]               rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Slow data-memory target: accepts one req, waits WAIT_CYCLES, accesses, acks (ack WAIT_CYCLES+1 cycles after accept).
// One request in flight; req_i is ignored while busy, so throughput is one access per WAIT_CYCLES+3 cycles.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [1:0]            size_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  ack_o,
  output logic                  err_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  busy_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_t                 state;
  logic [3:0]             cnt;
  logic                   r_we;
  logic [1:0]             r_size;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [DATA_WIDTH-1:0]  r_wdata;

  logic                   c_we;
  logic [1:0]             c_size;
  logic [ADDR_WIDTH-1:0]  c_addr;
  logic [DATA_WIDTH-1:0]  c_wdata;
  logic                   access;
  logic                   acc_err;
  logic [3:0]             wen;
  logic [DATA_WIDTH-1:0]  wrep;
  logic [DATA_WIDTH-1:0]  rword;

  // With no wait states the access happens on the accept edge, before the request is latched.
  always_comb begin
    if (state == ST_IDLE) begin
      c_we    = we_i;
      c_size  = size_i;
      c_addr  = addr_i;
      c_wdata = wdata_i;
    end else begin
      c_we    = r_we;
      c_size  = r_size;
      c_addr  = r_addr;
      c_wdata = r_wdata;
    end
  end

  assign access = !rst_i &&
                  ((state == ST_IDLE && req_i && WAIT_CYCLES == 0) ||
                   (state == ST_WAIT && cnt == 4'd1));

  assign acc_err = (|c_addr[ADDR_WIDTH-1:IDX_W+2]) ||
                   (c_size == 2'b11) ||
                   (c_size == SIZE_H && c_addr[0]) ||
                   (c_size == SIZE_W && |c_addr[1:0]);

  assign wrep = lane_data(c_size, c_wdata);
  assign wen  = (access && c_we && !acc_err) ? byte_en(c_size, c_addr[1:0]) : 4'b0000;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    dmem_bank_byte #(.DEPTH(DEPTH_WORDS)) u_bank (
      .clk   (clk_i),
      .we    (wen[i]),
      .addr  (c_addr[IDX_W+1:2]),
      .wdata (wrep[8*i +: 8]),
      .rdata (rword[8*i +: 8])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      busy_o  <= 1'b0;
      rdata_o <= '0;
      r_we    <= 1'b0;
      r_size  <= SIZE_W;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      ack_o <= 1'b0;
      if (access) begin
        err_o   <= acc_err;
        rdata_o <= (acc_err || c_we) ? '0 : rword;
      end
      case (state)
        ST_IDLE: begin
          if (req_i) begin
            r_we    <= we_i;
            r_size  <= size_i;
            r_addr  <= addr_i;
            r_wdata <= wdata_i;
            cnt     <= 4'(WAIT_CYCLES);
            busy_o  <= 1'b1;
            state   <= (WAIT_CYCLES == 0) ? ST_ACK : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= ST_ACK;
        end
        ST_ACK: begin
          ack_o <= 1'b1;
          state <= ST_HOLD;
        end
        default: begin
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
